line_ram_responder: RTL and testbench

LINE_RAM_RESPONDER -- requirements
Module: line_ram_responder

---
 rtl/line_ram_responder.sv | 130 +++++++++++++
 tb/tb_line_ram_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_ram_responder.sv
// Single-port line RAM responder: accepts one 128-bit line read or write at a time
// and answers after a fixed latency counted from the acceptance cycle.
module line_ram_responder #(
    parameter int DEPTH_LINES   = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic [31:0]  read_addr,
    input  logic         read_addr_valid,
    output logic         read_addr_ready,
    output logic [127:0] read_data,
    output logic         read_data_valid,
    input  logic [31:0]  write_addr,
    input  logic         write_addr_valid,
    output logic         write_addr_ready,
    input  logic [127:0] write_data,
    output logic         write_resp_valid
);
    localparam int         IDX_W   = $clog2(DEPTH_LINES);
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_next_s;
    logic [IDX_W-1:0] line_r;
    logic [IDX_W-1:0] line_next_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             wr_accept_s;
    logic             rd_fire_next_s;
    logic             wr_fire_next_s;
    logic [127:0]     read_data_r;
    logic             read_data_valid_r;
    logic             write_resp_valid_r;
    logic [127:0]     mem_r [DEPTH_LINES];
    logic             unused_addr_s;

    // Byte offset and bits above the line index are don't-care; addresses alias.
    assign rd_idx_s      = read_addr[IDX_W+3:4];
    assign wr_idx_s      = write_addr[IDX_W+3:4];
    assign unused_addr_s = ^{read_addr[31:IDX_W+4], read_addr[3:0],
                             write_addr[31:IDX_W+4], write_addr[3:0]};

    // Next-state, latency counter and line selection; readies decode from IDLE.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        line_next_s      = line_r;
        read_addr_ready  = 1'b0;
        write_addr_ready = 1'b0;
        wr_accept_s      = 1'b0;
        case (state_r)
            IDLE: begin
                read_addr_ready  = !RESET;
                write_addr_ready = !RESET && !read_addr_valid;
                if (!RESET && read_addr_valid) begin
                    state_next_s = READ_WAIT;
                    cnt_next_s   = RD_LOAD;
                    line_next_s  = rd_idx_s;
                end else if (!RESET && write_addr_valid) begin
                    wr_accept_s  = 1'b1;
                    state_next_s = WRITE_WAIT;
                    cnt_next_s   = WR_LOAD;
                    line_next_s  = wr_idx_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // The response cycle is the one whose counter value is zero, so the pulse
    // register is loaded one edge earlier (at acceptance when the latency is 1).
    assign rd_fire_next_s = (state_next_s == READ_WAIT)  && (cnt_next_s == 4'd0);
    assign wr_fire_next_s = (state_next_s == WRITE_WAIT) && (cnt_next_s == 4'd0);

    // Control state, counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r            <= IDLE;
            cnt_r              <= 4'd0;
            line_r             <= {IDX_W{1'b0}};
            read_data_r        <= 128'd0;
            read_data_valid_r  <= 1'b0;
            write_resp_valid_r <= 1'b0;
        end else begin
            state_r            <= state_next_s;
            cnt_r              <= cnt_next_s;
            line_r             <= line_next_s;
            read_data_valid_r  <= rd_fire_next_s;
            write_resp_valid_r <= wr_fire_next_s;
            if (rd_fire_next_s) begin
                read_data_r <= mem_r[line_next_s];
            end
        end
    end

    // Line storage; reset intentionally leaves contents untouched.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_idx_s] <= write_data;
        end
    end

    assign read_data        = read_data_r;
    assign read_data_valid  = read_data_valid_r;
    assign write_resp_valid = write_resp_valid_r;

endmodule

// File: tb/tb_line_ram_responder.sv
// Bench for line_ram_responder: directed latency/aliasing/reset scenarios plus random
// traffic, all checked every cycle against a due-cycle behavioural model.
module tb_line_ram_responder;
    localparam int DEPTH = 1024;
    localparam int RL    = 4;
    localparam int WL    = 4;
    localparam logic [127:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PAT2 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
    localparam logic [127:0] PAT3 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] PAT4 = 128'h0F0F0F0F_F0F0F0F0_12481248_84218421;
    localparam logic [127:0] PAT5 = 128'hFEDCBA98_76543210_00000001_80000000;

    logic         clk;
    logic         RESET;
    logic [31:0]  read_addr, write_addr;
    logic         read_addr_valid, write_addr_valid;
    logic         read_addr_ready, write_addr_ready;
    logic [127:0] read_data, write_data;
    logic         read_data_valid, write_resp_valid;

    logic [31:0]  l1_read_addr, l1_write_addr;
    logic         l1_read_addr_valid, l1_write_addr_valid;
    logic         l1_read_addr_ready, l1_write_addr_ready;
    logic [127:0] l1_read_data, l1_write_data;
    logic         l1_read_data_valid, l1_write_resp_valid;

    int n_tests;
    int n_fail;
    int cyc;
    int n_rd_req, n_wr_req, n_rd_acc, n_wr_acc;
    bit model_on;

    line_ram_responder #(.DEPTH_LINES(DEPTH), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .clk(clk), .RESET(RESET),
        .read_addr(read_addr), .read_addr_valid(read_addr_valid), .read_addr_ready(read_addr_ready),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .write_addr(write_addr), .write_addr_valid(write_addr_valid), .write_addr_ready(write_addr_ready),
        .write_data(write_data), .write_resp_valid(write_resp_valid)
    );

    line_ram_responder #(.DEPTH_LINES(16), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut_l1 (
        .clk(clk), .RESET(RESET),
        .read_addr(l1_read_addr), .read_addr_valid(l1_read_addr_valid), .read_addr_ready(l1_read_addr_ready),
        .read_data(l1_read_data), .read_data_valid(l1_read_data_valid),
        .write_addr(l1_write_addr), .write_addr_valid(l1_write_addr_valid), .write_addr_ready(l1_write_addr_ready),
        .write_data(l1_write_data), .write_resp_valid(l1_write_resp_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one outstanding request, a response due RL/WL cycles after acceptance.
    logic [127:0] m_mem [DEPTH];
    logic [127:0] m_rdata;
    bit           m_busy, m_is_read, e_rv, e_wv;
    int           m_due, m_line;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 128'd0;
        m_rdata = 128'd0;
        forever begin
            @(negedge clk);
            if (model_on) begin
                e_rv = m_busy && m_is_read && (m_due == cyc);
                e_wv = m_busy && !m_is_read && (m_due == cyc);
                if (e_rv) m_rdata = m_mem[m_line];
                checkb("m_read_data_valid", read_data_valid, e_rv);
                checkb("m_write_resp_valid", write_resp_valid, e_wv);
                check("m_read_data", read_data, m_rdata);
                checkb("m_read_addr_ready", read_addr_ready, !m_busy && !RESET);
                checkb("m_write_addr_ready", write_addr_ready, !m_busy && !RESET && !read_addr_valid);
                if (read_addr_valid && read_addr_ready) n_rd_acc++;
                if (write_addr_valid && write_addr_ready) n_wr_acc++;
                if (RESET) begin
                    m_busy  = 1'b0;
                    m_rdata = 128'd0;
                end else if (m_busy) begin
                    if (m_due == cyc) m_busy = 1'b0;
                end else if (read_addr_valid) begin
                    m_busy = 1'b1; m_is_read = 1'b1;
                    m_line = int'(read_addr[13:4]);
                    m_due  = cyc + RL;
                end else if (write_addr_valid) begin
                    m_busy = 1'b1; m_is_read = 1'b0;
                    m_mem[int'(write_addr[13:4])] = write_data;
                    m_due  = cyc + WL;
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [127:0] d);
        int k = 0;
        write_addr = a; write_data = d; write_addr_valid = 1'b1; n_wr_req++;
        #1;
        while (!write_addr_ready && k < 40) begin tick(); #1; k++; end
        if (k >= 40) check_int("write_accept_timeout", k, 0);
        tick();
        write_addr_valid = 1'b0; write_addr = $urandom;
        write_data = {$urandom, $urandom, $urandom, $urandom};
        k = 0;
        while (!write_resp_valid && k < 40) begin tick(); k++; end
        if (k >= 40) check_int("write_resp_timeout", k, 0);
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [127:0] d);
        int k = 0;
        read_addr = a; read_addr_valid = 1'b1; n_rd_req++;
        #1;
        while (!read_addr_ready && k < 40) begin tick(); #1; k++; end
        if (k >= 40) check_int("read_accept_timeout", k, 0);
        tick();
        read_addr_valid = 1'b0; read_addr = $urandom;
        k = 0;
        while (!read_data_valid && k < 40) begin tick(); k++; end
        if (k >= 40) check_int("read_resp_timeout", k, 0);
        d = read_data;
        tick();
    endtask

    initial begin
        logic [127:0] d;
        int k;
        RESET = 1'b1;
        read_addr = 32'd0; read_addr_valid = 1'b0;
        write_addr = 32'd0; write_addr_valid = 1'b0; write_data = 128'd0;
        l1_read_addr = 32'd0; l1_read_addr_valid = 1'b0;
        l1_write_addr = 32'd0; l1_write_addr_valid = 1'b0; l1_write_data = 128'd0;
        repeat (2) tick();
        model_on = 1'b1;
        check("reset_read_data", read_data, 128'd0);
        checkb("reset_read_valid", read_data_valid, 1'b0);
        checkb("reset_write_resp", write_resp_valid, 1'b0);
        tick();
        RESET = 1'b0;
        #1;
        checkb("idle_read_ready", read_addr_ready, 1'b1);
        checkb("idle_write_ready", write_addr_ready, 1'b1);

        // Write at T, response at T+4; read accepted at T+5 answers at T+9.
        tick();
        write_addr = 32'h0000_1230; write_data = PAT; write_addr_valid = 1'b1; n_wr_req++;
        #1;
        checkb("t1_write_ready", write_addr_ready, 1'b1);
        tick();
        write_addr_valid = 1'b0; write_data = 128'd0;
        for (int i = 1; i <= 4; i++) begin
            checkb("t1_write_resp_timing", write_resp_valid, (i == 4));
            if (i < 4) tick();
        end
        tick();
        read_addr = 32'h0000_1230; read_addr_valid = 1'b1; n_rd_req++;
        #1;
        checkb("t1_read_ready", read_addr_ready, 1'b1);
        tick();
        read_addr_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checkb("t1_read_valid_timing", read_data_valid, (i == 4));
            if (i < 4) tick();
        end
        check("t1_read_data", read_data, PAT);
        tick();

        // Simultaneous read and write: read wins, write waits for the next IDLE cycle.
        read_addr = 32'h0000_1230; read_addr_valid = 1'b1; n_rd_req++;
        write_addr = 32'h0000_2340; write_data = PAT2; write_addr_valid = 1'b1; n_wr_req++;
        #1;
        checkb("t2_read_ready", read_addr_ready, 1'b1);
        checkb("t2_write_held", write_addr_ready, 1'b0);
        tick();
        read_addr_valid = 1'b0;
        #1;
        k = 1;
        while (!write_addr_ready && k < 20) begin tick(); k++; end
        check_int("t2_write_accept_cycle", k, RL + 1);
        tick();
        write_addr_valid = 1'b0;
        repeat (WL + 1) tick();
        do_read(32'h0000_2348, d);
        check("t2_read_back", d, PAT2);

        // Pre-fill lines 0..7 so random traffic only reads written lines.
        for (int i = 0; i < 8; i++) do_write(32'(i) << 4, {$urandom, $urandom, $urandom, $urandom});

        // Aliasing: line 1 via 0x10, read back via 0x401C.
        do_write(32'h0000_0010, PAT3);
        do_read(32'h0000_401C, d);
        check("t3_alias", d, PAT3);

        // Reset two cycles into READ_WAIT aborts the read, memory survives.
        do_write(32'h0000_0050, PAT4);
        read_addr = 32'h0000_0050; read_addr_valid = 1'b1; n_rd_req++;
        #1;
        checkb("t4_read_ready", read_addr_ready, 1'b1);
        tick();
        read_addr_valid = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        check("t4_read_data_cleared", read_data, 128'd0);
        checkb("t4_read_ready_after", read_addr_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkb("t4_no_pulse", read_data_valid, 1'b0);
            tick();
        end
        do_read(32'h0000_0050, d);
        check("t4_data_kept", d, PAT4);

        // Latency-1 instance: response next cycle, back-to-back reads every 2 cycles.
        l1_write_addr = 32'h0000_0030; l1_write_data = PAT5; l1_write_addr_valid = 1'b1;
        #1;
        checkb("l1_write_ready", l1_write_addr_ready, 1'b1);
        tick();
        l1_write_addr_valid = 1'b0;
        #1;
        checkb("l1_write_resp", l1_write_resp_valid, 1'b1);
        checkb("l1_busy_ready", l1_read_addr_ready, 1'b0);
        tick();
        checkb("l1_write_resp_single", l1_write_resp_valid, 1'b0);
        l1_read_addr = 32'h0000_003C; l1_read_addr_valid = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            checkb("l1_read_ready", l1_read_addr_ready, (i % 2 == 0));
            checkb("l1_read_valid", l1_read_data_valid, (i % 2 == 1));
            if (i % 2 == 1) check("l1_read_data", l1_read_data, PAT5);
            tick();
            #1;
        end
        l1_read_addr_valid = 1'b0;

        check_int("read_accepts", n_rd_acc, n_rd_req);
        check_int("write_accepts", n_wr_acc, n_wr_req);

        // Random traffic over lines 0..7 with random alias/offset bits and rare resets.
        for (int c = 0; c < 400; c++) begin
            tick();
            read_addr_valid  = ($urandom_range(0, 2) == 0);
            read_addr        = $urandom & 32'hFFFF_C07F;
            write_addr_valid = ($urandom_range(0, 2) == 0);
            write_addr       = $urandom & 32'hFFFF_C07F;
            write_data       = {$urandom, $urandom, $urandom, $urandom};
            RESET            = ($urandom_range(0, 60) == 0);
        end
        tick();
        RESET = 1'b0; read_addr_valid = 1'b0; write_addr_valid = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
